// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
//
// Purpose:
//   Accepts parallel words over a valid/ready handshake and emits them one bit
//   per clock on a serial output, for a downstream sequence recognizer. A
//   one-word holding register lets the next word be accepted while the current
//   word is still shifting, so consecutive words stream with no idle cycles.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 of each word is sent first; 0: bit 0 first
//
// Ports:
//   clk         in   single clock, rising-edge
//   reset       in   asynchronous, active-high reset
//   data_in     in   [WIDTH-1:0] parallel word from the source
//   data_valid  in   source has a word on data_in
//   data_ready  out  block can accept a word this cycle (registered decode)
//   out         out  serial bit (0 whenever out_valid is 0)
//   out_valid   out  out carries a valid bit this cycle
//   word_done   out  high while the last bit of a word is presented
//   busy        out  shifting, or a word is waiting in the holding register
// ---------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             cur_bit;
  logic [WIDTH-1:0] sh_shifted;

  // Ready depends only on the holding-register flag, so there is no
  // combinational path from data_valid to data_ready.
  assign data_ready = ~hold_full_q;
  assign accept     = data_valid & data_ready;

  assign shifting = (state_q == ST_SHIFT);
  assign last_bit = shifting && (cnt_q == CNT_LAST);

  // The bit on the wire is always taken from the same end of sh; the
  // register moves toward that end each cycle.
  assign cur_bit    = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
  assign sh_shifted = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      ST_IDLE: begin
        // The holding register is never occupied here, so an accepted
        // word goes straight into the shift register.
        if (accept) begin
          sh_d    = data_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!last_bit) begin
          sh_d  = sh_shifted;
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // data_ready is low this cycle, so no new word competes with
          // the held one.
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word arriving exactly at the boundary bypasses the holding
          // register to keep the stream gap-free.
          sh_d  = data_in;
          cnt_d = '0;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        hold_full_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign out_valid = shifting;
  assign out       = shifting & cur_bit;
  assign word_done = last_bit;
  assign busy      = shifting | hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Drives two instances (MSB-first and LSB-first) from the same handshake.
// Each accepted word appends its bits, in transmission order, to a per-DUT
// expected-bit queue; a monitor pops one entry per presented bit. The stream
// is modelled purely as a queue of pending bits: a bit is on the wire iff the
// queue is non-empty, and the block can take another word iff at most one
// word's worth of bits is outstanding.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;

  logic rdy_m, out_m, ov_m, wd_m, busy_m;
  logic rdy_l, out_l, ov_l, wd_l, busy_l;

  ent_t q_m[$];
  ent_t q_l[$];
  logic mdl_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_m), .out(out_m), .out_valid(ov_m), .word_done(wd_m),
    .busy(busy_m)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_l), .out(out_l), .out_valid(ov_l), .word_done(wd_l),
    .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_m.push_back('{b: w[W-1-i], last: (i == W-1)});
      q_l.push_back('{b: w[i],     last: (i == W-1)});
    end
  endtask

  task automatic check_stream(input string tag, input logic ov, input logic o,
                              input logic wd, input logic bs, input logic rd,
                              input int qsz, input ent_t head);
    chk({tag, "_out_valid"}, ov, (qsz > 0));
    if (qsz > 0) begin
      chk({tag, "_out"}, o, head.b);
      chk({tag, "_word_done"}, wd, head.last);
    end else begin
      chk({tag, "_out_idle"}, o, 1'b0);
      chk({tag, "_word_done_idle"}, wd, 1'b0);
    end
    chk({tag, "_busy"}, bs, (qsz > 0));
    chk({tag, "_data_ready"}, rd, mdl_ready);
  endtask

  // Monitor: compares what each DUT presents this cycle with the head of its
  // queue, then retires that bit (it is consumed by the coming edge).
  initial begin
    ent_t hm, hl;
    forever begin
      @(negedge clk);
      mdl_ready = (q_m.size() <= W);
      hm = (q_m.size() > 0) ? q_m[0] : '0;
      hl = (q_l.size() > 0) ? q_l[0] : '0;
      check_stream("msb", ov_m, out_m, wd_m, busy_m, rdy_m, q_m.size(), hm);
      check_stream("lsb", ov_l, out_l, wd_l, busy_l, rdy_l, q_l.size(), hl);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
    end
  end

  // One clock of stimulus, entered and left at 1ns after a rising edge.
  task automatic cycle_drive(output logic acc);
    @(negedge clk);
    #1;
    acc = data_valid && mdl_ready && !reset;
    if (acc) push_word(data_in);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    data_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle_drive(a);
  endtask

  task automatic send(input logic [W-1:0] w, input int gap);
    logic acc;
    int   n;
    idle(gap);
    data_in    = w;
    data_valid = 1'b1;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 100) begin
      cycle_drive(acc);
      n++;
    end
    chk("send_accepted", acc, 1'b1);
    data_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must fall before any edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", ov_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_out", out_m, 1'b0);
    chk("rst_word_done", wd_m, 1'b0);
    chk("rst_data_ready", rdy_m, 1'b1);
    chk("rst_lsb_out_valid", ov_l, 1'b0);
    chk("rst_lsb_busy", busy_l, 1'b0);
    q_m.delete();
    q_l.delete();
    // A word offered during reset must not be taken.
    data_in    = W'($urandom);
    data_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic a;
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_out_valid", ov_m, 1'b0);
    chk("reset_busy", busy_m, 1'b0);
    chk("reset_data_ready", rdy_m, 1'b1);
    reset = 1'b0;
    idle(2);

    // Single word, then enough idle for the stream to end.
    send(8'hE0, 0);
    idle(12);

    // LSB-first path sees 8'h01 as a 1 followed by zeros.
    send(8'h01, 0);
    idle(12);

    // Back-to-back with valid held: second word held, third and fourth stall.
    send(8'hA5, 0);
    send(8'h3C, 0);
    send(8'hFF, 0);
    send(8'h5A, 0);
    idle(40);

    // Reset in the middle of a word with another word held.
    send(8'hA5, 2);
    send(8'h3C, 0);
    idle(2);
    do_reset();
    idle(4);
    send(8'h96, 0);
    idle(12);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 250; k++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(W'($urandom), gap);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    data_valid = 1'b0;
    n = 0;
    while (q_m.size() > 0 && n < 100) begin
      cycle_drive(a);
      n++;
    end
    chk("drain_complete", q_m.size(), 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
